alu_multicycle: RTL

//  Execution unit that consumes the 3-bit ALUCtrl code produced by ALU_Control plus two operands.
//  OR/AND/ADD/SUB complete in one cycle; MUL runs on an iterative shift-add engine with a

---
 rtl/alu_multicycle_pkg.sv | 9 +
 rtl/mul_shift_add.sv | 53 +++++
 rtl/alu_multicycle.sv | 88 ++++++++
 3 files changed

// File: rtl/alu_multicycle_pkg.sv
// alu_multicycle_pkg: operation codes and FSM state type shared by the ALU files
package alu_multicycle_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    typedef enum logic {ST_IDLE, ST_MUL_RUN} alu_state_e;
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier retiring RADIX multiplier bits per cycle
module mul_shift_add #(
    parameter int WIDTH = 32,
    parameter int RADIX = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int N  = WIDTH / RADIX;
    localparam int CW = $clog2(N + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_step;
    // one iteration: add multiplicand times the low RADIX multiplier bits; done when the last one retires
    always_comb begin
        acc_step  = acc_q + mcand_q * {{(WIDTH-RADIX){1'b0}}, mplier_q[RADIX-1:0]};
        done_o    = cnt_q == CW'(1);
        product_o = acc_step;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        if (start_i) begin
            cnt_d    = CW'(N);
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CW'(1);
            acc_d    = acc_step;
            mcand_d  = mcand_q << RADIX;
            mplier_d = mplier_q >> RADIX;
        end
    end
    // counter, accumulator and shifting operand registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU, single-cycle logic ops and add/sub, iterative MUL with valid/ready
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_RADIX = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             illegal_o
);
    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, alu_res, mul_prod;
    logic             valid_q, valid_d, zero_q, zero_d, illegal_q, illegal_d;
    logic             single_op, mul_start, mul_done;
    mul_shift_add #(.WIDTH(WIDTH), .RADIX(MUL_RADIX)) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (mul_start),
        .a_i      (data1_i),
        .b_i      (data2_i),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );
    // single-cycle datapath
    always_comb begin
        alu_res   = ALUCtrl_i == ALU_AND ? data1_i & data2_i :
                    ALUCtrl_i == ALU_OR  ? data1_i | data2_i :
                    ALUCtrl_i == ALU_ADD ? data1_i + data2_i :
                    ALUCtrl_i == ALU_SUB ? data1_i - data2_i : '0;
        single_op = ALUCtrl_i inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB};
    end
    // FSM next state and result capture; undefined codes report a zero result flagged illegal
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;
        if (state_q == ST_IDLE) begin
            if (valid_i && ALUCtrl_i == ALU_MUL) begin
                mul_start = 1'b1;
                state_d   = ST_MUL_RUN;
            end else if (valid_i) begin
                data_d    = single_op ? alu_res : '0;
                zero_d    = single_op ? alu_res == '0 : 1'b1;
                illegal_d = !single_op;
                valid_d   = 1'b1;
            end
        end else if (mul_done) begin
            data_d    = mul_prod;
            zero_d    = mul_prod == '0;
            illegal_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = ST_IDLE;
        end
        ready_o   = state_q == ST_IDLE;
        valid_o   = valid_q;
        data_o    = data_q;
        zero_o    = zero_q;
        illegal_o = illegal_q;
    end
    // state and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
        end
    end
endmodule
